inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL provide parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: imem_req  output  1  instruction-memory request.
REQ-005 SHALL have port: imem_addr  output  32  word-aligned fetch address.
REQ-006 SHALL have port: imem_ack  input  1  memory completes the transaction this cycle.
REQ-007 SHALL have port: imem_data  input  32  instruction word, valid only when imem_ack=1.
REQ-008 SHALL have port: inst  output  32  registered instruction, feeds the instruction decoder.
REQ-009 SHALL have port: inst_pc  output  32  address of inst.
REQ-010 SHALL have port: inst_valid  output  1  inst/inst_pc hold a deliverable instruction.
REQ-011 SHALL have port: stall  input  1  consumer not ready; the instruction is consumed on an edge with inst_valid=1 and stall=0.
REQ-012 SHALL have port: redirect  input  1  taken branch/jump; flush and refetch.
REQ-013 SHALL have port: redirect_pc  input  32  target address; bits [1:0] are forced to 0.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, DISCARD, HOLD; imem_req=1 only in FETCH and DISCARD.
REQ-015 SHALL leave IDLE for FETCH unconditionally on the first edge after reset release.
REQ-016 SHALL hold imem_addr stable while imem_req=1 and imem_ack=0; at most one request outstanding.
REQ-017 FETCH, ack=1, redirect=0: SHALL load inst<=imem_data, inst_pc<=pc, set inst_valid<=1, pc<=pc+4 (mod 2^32 wrap), go to HOLD.
REQ-018 FETCH, ack=1, redirect=1: SHALL drop the data, set pc<=redirect_pc, and stay in FETCH.
REQ-019 FETCH, ack=0, redirect=1: SHALL latch pend_pc<=redirect_pc and go to DISCARD.
REQ-020 DISCARD, redirect=1: SHALL overwrite pend_pc (latest target wins).
REQ-021 DISCARD, ack=1: SHALL drop the data, set pc<=pend_pc (or redirect_pc if redirect=1 in the same cycle), and go to FETCH.
REQ-022 HOLD, redirect=1: SHALL clear inst_valid, set pc<=redirect_pc, and go to FETCH, regardless of stall.
REQ-023 HOLD, stall=0, redirect=0: SHALL clear inst_valid and go to FETCH; the next request is issued the following cycle.
REQ-024 HOLD, stall=1, redirect=0: SHALL hold inst, inst_pc and inst_valid unchanged.
REQ-025 SHALL keep inst and inst_pc unchanged whenever no new instruction is accepted.
REQ-026 Latency: SHALL assert inst_valid on the edge that samples imem_ack in FETCH; with no stalls, best-case throughput is 1 instruction per 2 cycles.
REQ-027 imem_addr SHALL equal pc at all times.

Reset
REQ-028 rst_n=0 SHALL immediately force: state=IDLE, pc=RESET_PC, pend_pc=0, inst=0, inst_pc=0, inst_valid=0, imem_req=0.
REQ-029 Reset asserted mid-transaction SHALL abandon the request; the first post-reset request SHALL be to RESET_PC, and any ack arriving in IDLE SHALL be ignored.

Configuration
REQ-030 With macro INST_FETCH_PERF_EN defined, SHALL add output ports perf_fetched (32, increments per instruction consumed) and perf_stall (32, increments each cycle in HOLD with stall=1).
REQ-031 With INST_FETCH_PERF_EN defined, both counters SHALL reset to 0 and wrap at 2^32.
REQ-032 Without INST_FETCH_PERF_EN, these ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Release reset, imem always acks: imem_addr sequence 0x0,0x4,0x8; inst_valid pulses with inst_pc 0x0,0x4,0x8.
REQ-034 Ack delayed 3 cycles at addr 0x10: imem_addr stays 0x10 and imem_req stays 1 for all 4 cycles.
REQ-035 redirect=1 to 0x200 while FETCH at 0x8 with ack=0, ack arrives 2 cycles later with 0xDEADBEEF: data dropped, inst_valid stays 0, next request is 0x200.
REQ-036 HOLD with stall=1 for 5 cycles, then redirect to 0x103: inst_valid clears, next imem_addr=0x100; with PERF_EN, perf_stall advances by 5.
REQ-037 rst_n pulsed low while FETCH at 0x40 is pending: outputs clear asynchronously; first post-reset request is to RESET_PC.
REQ-038 pc=0xFFFF_FFFC fetched and consumed: next imem_addr=0x0000_0000.

Source files
------------

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Purpose:
//   Single-outstanding instruction fetch unit. Issues one word-aligned request
//   at a time to the instruction memory and holds the returned word in an
//   output register until the decoder consumes it. Taken branches and jumps
//   arrive on redirect/redirect_pc. A request already in flight when a
//   redirect arrives is allowed to complete, and its data is dropped.
//
// Optional feature:
//   INST_FETCH_PERF_EN adds the perf_fetched and perf_stall counters and
//   their output ports. With the macro undefined they are absent.
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous, active-low reset
//   imem_req     out  1   instruction-memory request (FETCH and DISCARD)
//   imem_addr    out  32  fetch address, always equal to pc
//   imem_ack     in   1   memory completes the transaction this cycle
//   imem_data    in   32  instruction word, valid with imem_ack
//   inst         out  32  registered instruction for the decoder
//   inst_pc      out  32  address of inst
//   inst_valid   out  1   inst/inst_pc hold a deliverable instruction
//   stall        in   1   consumer not ready
//   redirect     in   1   taken branch/jump: flush and refetch
//   redirect_pc  in   32  redirect target; bits [1:0] are ignored
//   perf_fetched out  32  instructions consumed (INST_FETCH_PERF_EN only)
//   perf_stall   out  32  cycles spent in HOLD with stall=1 (INST_FETCH_PERF_EN only)
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic [31:0] target;

    assign target    = {redirect_pc[31:2], 2'b00};
    assign imem_addr = pc;

    // imem_req is registered together with the state. It is set on every
    // transition into FETCH or DISCARD and cleared on every transition into
    // IDLE or HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pend_pc    <= 32'h0;
            inst       <= 32'h0;
            inst_pc    <= 32'h0;
            inst_valid <= 1'b0;
            imem_req   <= 1'b0;
        end else begin
            case (state)
                // Any ack seen here belongs to a request abandoned by reset.
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            // The returned word is on the wrong path. Refetch
                            // from the target at once.
                            pc <= target;
                        end else begin
                            inst       <= imem_data;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            pc         <= pc + 32'd4;
                            state      <= HOLD;
                            imem_req   <= 1'b0;
                        end
                    end else if (redirect) begin
                        // The request must finish at its original address, so
                        // the target is parked until the ack arrives.
                        pend_pc <= target;
                        state   <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        pc    <= redirect ? target : pend_pc;
                        state <= FETCH;
                    end else if (redirect) begin
                        pend_pc <= target;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        inst_valid <= 1'b0;
                        pc         <= target;
                        state      <= FETCH;
                        imem_req   <= 1'b1;
                    end else if (!stall) begin
                        inst_valid <= 1'b0;
                        state      <= FETCH;
                        imem_req   <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef INST_FETCH_PERF_EN
    // An instruction counts as consumed on any edge where it is valid and not
    // stalled, including an edge that also carries a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'h0;
            perf_stall   <= 32'h0;
        end else begin
            if (inst_valid && !stall)
                perf_fetched <= perf_fetched + 32'd1;
            if (state == HOLD && stall)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
